fifo_wr_arbiter_rr: RTL and testbench

// Round-robin write arbiter sharing the single write port of synch_fifo_16x8bit among
// N_REQ producers. Each producer uses a valid/ready handshake. The arbiter drives the

---
 rtl/fifo_wr_arbiter_rr_if.sv | 29 ++
 rtl/fifo_wr_arbiter_rr.sv | 117 +++++++++++
 tb/tb_fifo_wr_arbiter_rr.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_rr_if.sv
// Write-port bundle between N_REQ valid/ready producers, the round-robin
// arbiter and the shared FIFO write port.
interface fifo_wr_arbiter_rr_if #(
  parameter int DATA_SIZE = 8,
  parameter int N_REQ     = 4
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*DATA_SIZE-1:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic                       fifo_full;
  logic                       fifo_wr_en;
  logic [DATA_SIZE-1:0]       fifo_data_in;
  logic [IW-1:0]              grant_id;
  logic                       burst_active;

  // Arbiter view: consumes requests and FIFO status, drives the write port.
  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id, burst_active
  );

  // Environment view: producers plus the FIFO.
  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id, burst_active
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers;
// a grantee may keep the port for up to MAX_BURST consecutive words.
module fifo_wr_arbiter_rr #(
  parameter int DATA_SIZE = 8,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             reset,
  fifo_wr_arbiter_rr_if.master bus
);
  localparam int          IW       = $clog2(N_REQ);
  localparam int          CW       = $clog2(MAX_BURST + 1);
  localparam int unsigned NR       = N_REQ;
  localparam logic [IW-1:0] LAST_ID  = IW'(N_REQ - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e        state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] owner_q;
  logic [CW-1:0] cnt_q;

  logic          cand_vld;
  logic [IW-1:0] cand_id;
  logic [IW-1:0] try_id;
  int unsigned   idx;
  logic          gnt_vld;
  logic [IW-1:0] gnt_id;
  logic          xfer;

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ
  // (N_REQ need not be a power of two, hence the explicit modulo).
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    try_id   = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx    = ({{(32-IW){1'b0}}, rr_ptr_q} + k) % NR;
      try_id = idx[IW-1:0];
      if (!cand_vld && bus.req_valid[try_id]) begin
        cand_vld = 1'b1;
        cand_id  = try_id;
      end
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (!reset) begin
      if (state_q == LOCK) begin
        gnt_vld = 1'b1;
        gnt_id  = owner_q;
      end else begin
        gnt_vld = cand_vld;
        gnt_id  = cand_id;
      end
    end
    xfer = gnt_vld && bus.req_valid[gnt_id] && !bus.fifo_full;
  end

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[gnt_id] = 1'b1;
    bus.fifo_wr_en   = xfer;
    bus.fifo_data_in = gnt_vld ? bus.req_data[gnt_id*DATA_SIZE +: DATA_SIZE] : '0;
    bus.grant_id     = gnt_id;
    bus.burst_active = (state_q == LOCK) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (MAX_BURST == 1) begin
              rr_ptr_q <= next_id(cand_id);
            end else begin
              state_q <= LOCK;
              owner_q <= cand_id;
              cnt_q   <= CW'(1);
            end
          end
        end
        LOCK: begin
          // A bubble from the owner ends the burst; a full FIFO only stalls it.
          if (!bus.req_valid[owner_q]) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_id(owner_q);
            cnt_q    <= '0;
          end else if (!bus.fifo_full) begin
            if (cnt_q == LAST_CNT) begin
              state_q  <= IDLE;
              rr_ptr_q <= next_id(owner_q);
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter_rr.sv
// Bench for fifo_wr_arbiter_rr: queue-based producers, a 16-deep FIFO model
// and a rule-level arbiter model checked every cycle.
module tb_fifo_wr_arbiter_rr;
  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_rr_if #(.DATA_SIZE(DW), .N_REQ(NR)) bus ();

  fifo_wr_arbiter_rr #(.DATA_SIZE(DW), .N_REQ(NR), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  src_q [NR][$];
  logic [7:0]  fifo_q [$];
  logic        rd_en = 1'b0;
  int unsigned nxt_seq [NR];
  int unsigned exp_seq [NR];
  int          gq [$];
  int          wq [$];

  logic          s_we, s_ba, s_full;
  logic [NR-1:0] s_rdy;
  logic [1:0]    s_gid;
  logic [DW-1:0] s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    logic [1:0] ix;
    for (int i = 0; i < NR; i++) begin
      ix = i[1:0];
      if (src_q[i].size() > 0) begin
        bus.req_valid[ix]        = 1'b1;
        bus.req_data[i*DW +: DW] = src_q[i][0];
      end else begin
        bus.req_valid[ix]        = 1'b0;
        bus.req_data[i*DW +: DW] = '0;
      end
    end
    bus.fifo_full = (fifo_q.size() >= DEPTH);
  endtask

  // Word encoding {requester, per-requester sequence} lets the FIFO reader
  // verify per-producer ordering without tracking interleaving.
  task automatic load(input int r, input int n);
    for (int k = 0; k < n; k++) begin
      src_q[r].push_back({r[1:0], nxt_seq[r][5:0]});
      nxt_seq[r]++;
    end
    drive();
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    logic [7:0] w;
    logic [1:0] id;
    @(negedge clk);
    s_we   = bus.fifo_wr_en;
    s_rdy  = bus.req_ready;
    s_gid  = bus.grant_id;
    s_ba   = bus.burst_active;
    s_data = bus.fifo_data_in;
    s_full = bus.fifo_full;
    if (!reset) begin
      wq.push_back(int'(s_we));
      if (s_we) gq.push_back(int'(s_gid));
    end
    @(posedge clk);
    #1;
    if (rd_en && fifo_q.size() > 0) begin
      w  = fifo_q.pop_front();
      id = w[7:6];
      chk("fifo_order", 32'(w[5:0]), 32'(exp_seq[id][5:0]));
      exp_seq[id]++;
    end
    for (int i = 0; i < NR; i++)
      if (s_rdy[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (s_we) begin
      chk("write_while_full", 32'(s_full), 0);
      fifo_q.push_back(s_data);
    end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin
      step();
      chk("rst_wr_en", 32'(s_we), 0);
      chk("rst_ready", 32'(s_rdy), 0);
      chk("rst_burst", 32'(s_ba), 0);
    end
    reset = 1'b0;
    gq.delete();
    wq.delete();
  endtask

  task automatic drain();
    int c = 0;
    rd_en = 1'b1;
    while ((fifo_q.size() > 0 || !srcs_empty()) && c < 400) begin
      step();
      c++;
    end
    rd_en = 1'b0;
    chk("drain_done", 32'(fifo_q.size() == 0 && srcs_empty()), 1);
  endtask

  task automatic chk_gq(input string name, input int exp[$]);
    for (int k = 0; k < exp.size(); k++)
      chk(name, (k < gq.size()) ? 32'(gq[k]) : 32'hFFFF_FFFF, 32'(exp[k]));
  endtask

  task automatic wait_gq(input int n, input int bound);
    int c = 0;
    while (gq.size() < n && c < bound) begin
      step();
      c++;
    end
    chk("wait_grants", 32'(gq.size() >= n), 1);
  endtask

  // Rule-level model: tracks "who may write" (rotation pointer, locked owner,
  // words in current burst) and derives outputs from the current inputs.
  int m_ptr   = 0;
  int m_owner = 0;
  int m_cnt   = 0;
  bit m_lock  = 1'b0;

  initial begin
    logic [NR-1:0] v, e_rdy;
    logic [DW-1:0] e_data;
    logic          f, r, x;
    logic [1:0]    ix;
    int            g;
    forever begin
      @(negedge clk);
      v = bus.req_valid;
      f = bus.fifo_full;
      r = reset;
      g = -1;
      if (!r) begin
        if (m_lock) g = m_owner;
        else
          for (int k = 0; k < NR; k++) begin
            ix = 2'((m_ptr + k) % NR);
            if (g < 0 && v[ix]) g = int'(ix);
          end
      end
      ix     = (g >= 0) ? g[1:0] : 2'd0;
      x      = (g >= 0) && v[ix] && !f;
      e_rdy  = '0;
      if (x) e_rdy[ix] = 1'b1;
      e_data = (g >= 0) ? bus.req_data[g*DW +: DW] : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
      chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(x));
      chk("fifo_data_in", 32'(bus.fifo_data_in), 32'(e_data));
      chk("grant_id", 32'(bus.grant_id), (g >= 0) ? 32'(g) : 0);
      chk("burst_active", 32'(bus.burst_active), 32'(m_lock && !r));
      @(posedge clk);
      if (r) begin
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_lock = 1'b0;
      end else if (!m_lock) begin
        if (x) begin
          if (MB == 1) m_ptr = (g + 1) % NR;
          else begin m_lock = 1'b1; m_owner = g; m_cnt = 1; end
        end
      end else if (!v[ix]) begin
        m_lock = 1'b0; m_ptr = (m_owner + 1) % NR; m_cnt = 0;
      end else if (x) begin
        m_cnt++;
        if (m_cnt == MB) begin
          m_lock = 1'b0; m_ptr = (m_owner + 1) % NR; m_cnt = 0;
        end
      end
    end
  end

  initial begin
    int c;
    for (int i = 0; i < NR; i++) begin nxt_seq[i] = 0; exp_seq[i] = 0; end
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;

    // All four requesting through reset; rotation 0..3 in bursts of four.
    load(0, 5); load(1, 5); load(2, 5); load(3, 5);
    do_reset();
    rd_en = 1'b1;
    wait_gq(17, 60);
    chk_gq("rr_sequence", '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0});
    drain();

    // Requester 1 drops after two words: one bubble, then requester 3.
    do_reset();
    load(1, 2); load(3, 3);
    rd_en = 1'b1;
    repeat (8) step();
    chk_gq("drop_grants", '{1,1,3,3,3});
    for (int k = 0; k < 6; k++)
      chk("drop_wr_trace", (k < wq.size()) ? 32'(wq[k]) : 32'hFFFF_FFFF,
          (k == 2) ? 0 : 1);
    drain();

    // Burst by 2 leaves the pointer at 3; then 3 wins before 0 (wrap).
    do_reset();
    rd_en = 1'b1;
    load(2, 4);
    c = 0;
    while (src_q[2].size() > 0 && c < 20) begin step(); c++; end
    chk("wrap_setup", 32'(src_q[2].size()), 0);
    gq.delete();
    load(0, 4); load(3, 4);
    wait_gq(8, 40);
    chk_gq("wrap_grants", '{3,3,3,3,0,0,0,0});
    drain();

    // FIFO fills at the second word of requester 1's fourth burst.
    do_reset();
    rd_en = 1'b0;
    load(3, 2);
    repeat (4) step();
    load(1, 16);
    c = 0;
    while (fifo_q.size() < DEPTH && c < 40) begin step(); c++; end
    chk("fill_to_full", 32'(fifo_q.size()), DEPTH);
    step();
    chk("full_stall_we", 32'(s_we), 0);
    chk("full_stall_ba", 32'(s_ba), 1);
    chk("full_stall_gid", 32'(s_gid), 1);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    step();
    chk("resume_we_3", 32'(s_we), 1);
    chk("resume_gid_3", 32'(s_gid), 1);
    step();
    chk("restall_we", 32'(s_we), 0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    step();
    chk("resume_we_4", 32'(s_we), 1);
    step();
    chk("burst_done_ba", 32'(s_ba), 0);
    chk("burst_done_we", 32'(s_we), 0);
    drain();

    // Reset abandons owner 2's burst; rotation restarts at 0.
    do_reset();
    rd_en = 1'b1;
    load(2, 6); load(3, 2);
    wait_gq(2, 20);
    chk("pre_reset_ba", 32'(bus.burst_active), 1);
    reset = 1'b1;
    step();
    chk("mid_reset_ba", 32'(s_ba), 0);
    chk("mid_reset_we", 32'(s_we), 0);
    step();
    reset = 1'b0;
    gq.delete();
    wait_gq(6, 30);
    chk_gq("post_reset_grants", '{2,2,2,2,3,3});
    drain();

    for (int i = 0; i < NR; i++)
      chk("all_words_delivered", exp_seq[i], nxt_seq[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
